player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Player (pac-man) movement controller. It produces `player_x`/`player_y`, the top-left corner of the SIZE×SIZE sprite. The dot collision logic and the ghost collision logic consume these as their position input.
Direction buttons are synchronised and buffered as a pending turn. Pac-man style, a turn is applied only at grid-aligned positions, except reversals, which apply immediately. Position advances once per `frame_tick`, is clamped to the playfield, and returns to spawn on `soft_reset`. The block also drives the player sprite pixel for the current VGA scan position.

Parameters:
SIZE, 16, sprite edge in pixels
STEP, 2, pixels moved per frame_tick; must divide GRID
GRID, 8, turn-alignment grid, power of two
X_MIN, 0, leftmost legal player_x
X_MAX, 624, rightmost legal player_x (640-SIZE)
Y_MIN, 0, topmost legal player_y
Y_MAX, 464, bottommost legal player_y (480-SIZE)
SPAWN_X, 312, player_x after reset/soft_reset; multiple of GRID
SPAWN_Y, 232, player_y after reset/soft_reset; multiple of GRID

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous re-spawn request, one clk pulse, active high
frame_tick  input  1  one-clk pulse per video frame
btn_up  input  1  raw button, active high, asynchronous to clk
btn_down  input  1  raw button
btn_left  input  1  raw button
btn_right  input  1  raw button
h_cnt  input  11  current VGA horizontal scan position
v_cnt  input  10  current VGA vertical scan position
player_x  output  10  sprite x, registered
player_y  output  10  sprite y, registered
dir  output  2  current direction: 0 right, 1 left, 2 up, 3 down; registered
moving  output  1  1 while the player advances each frame; registered
player_pixel  output  1  combinational; 1 when (h_cnt,v_cnt) lies inside the sprite box

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `rst` is asynchronous and active-low: `player_x`=SPAWN_X, `player_y`=SPAWN_Y, `dir`=1 (left), `moving`=0, `pend_valid`=0, all synchroniser flops=0.
- Button synchronisation:
  - Each button passes through a 2-flop synchroniser.
  - A synchronised press is visible in `pend_dir` 3 clks after the raw edge: 2 synchroniser stages plus 1 capture.
- Pending-turn capture (every clk, not gated by `frame_tick`):
  - If any synchronised button is high, `pend_dir` <= the highest-priority one and `pend_valid` <= 1.
  - Priority: up > down > left > right.
  - A newer press overwrites `pend_dir`.
  - `pend_valid` stays set after release until it is consumed.
- Frame update, only on a clk where `frame_tick`=1 and `soft_reset`=0, evaluated in this order:
  1. Turn acceptance: if `pend_valid` and (`moving`=0, or `pend_dir` is the reverse of `dir`, or ((`player_x` mod GRID)==0 and (`player_y` mod GRID)==0)):
     - `dir` <= `pend_dir`, `moving` <= 1, `pend_valid` <= 0.
     - The move below uses the new direction in the same tick.
     - A capture and a consume on the same clk: the consume wins, and `pend_valid` ends at 0.
  2. Move, if moving (after step 1) in direction d:
     - If the coordinate already equals the bound in d: no position change, `moving` <= 0, `dir` unchanged.
     - Otherwise the coordinate <= `player+STEP` (right/down) or `player-STEP` (left/up), clamped to X_MAX/Y_MAX/X_MIN/Y_MIN.
     - Arithmetic is 11-bit so the left/up subtraction cannot wrap below 0; the result is clamped before truncation to 10 bits.
  3. A pending turn that is not accepted stays pending for later ticks.
- `soft_reset`:
  - Has priority over `frame_tick` on the same clk.
  - Sets outputs and `pend_valid` to the reset values.
  - Does not clear the synchroniser flops. A button held through `soft_reset` re-captures on the next clk.
- `player_pixel` = (`h_cnt` >= `player_x`) && (`h_cnt` < `player_x`+SIZE) && (`v_cnt` >= `player_y`) && (`v_cnt` < `player_y`+SIZE). Compare at 11 bits, zero-extending the 10-bit operands.
- Outputs change only on `frame_tick` (position, `dir`, `moving`), on `soft_reset`, or on `rst`. Between ticks they are stable.

Test Plan:
- Reset: deassert `rst`, no buttons, 5 `frame_tick`s -> `player_x`=312, `player_y`=232, `dir`=1, `moving`=0. Sample `h_cnt`=312,`v_cnt`=232 -> `player_pixel`=1; `h_cnt`=328 -> 0.
- Start and run: pulse `btn_right` 4 clks, wait 5 clks, then 3 `frame_tick`s -> `dir`=0, `moving`=1, `player_x` 312 -> 314 -> 316 -> 318.
- Grid-gated turn: moving right at x=314, press `btn_up` -> `dir` stays 0 for ticks giving x=316, 318, 320. On the tick where x=320 (aligned, y=232) the turn applies: `dir`=2, `player_y`=230, `player_x`=320.
- Immediate reversal: moving right at x=318, press `btn_left`, next `frame_tick` -> `dir`=1, `player_x`=316.
- Wall clamp:
  - Moving right at x=622: one tick -> x=624, `moving`=1; next tick -> x=624, `moving`=0.
  - Moving left at x=1 (STEP=2): one tick -> x=0.
- Priority and soft_reset:
  - Press `btn_up`+`btn_right` together -> `pend_dir`=up.
  - Assert `soft_reset` and `frame_tick` on the same clk while moving -> x=312, y=232, `dir`=1, `moving`=0, no movement that tick.

Source files
------------

// File: rtl/player_motion.sv
// player_motion: pac-man style movement controller.
//   Buttons are synchronised and latched as a pending turn; turns apply only
//   on grid-aligned positions (reversals apply at once). Position advances by
//   STEP on each frame_tick, clamped to the playfield.
// Ports:
//   clk, rst (async, active-low), soft_reset (sync re-spawn pulse)
//   frame_tick            one-clk pulse per video frame
//   btn_up/down/left/right raw asynchronous buttons
//   h_cnt, v_cnt          VGA scan position
//   player_x, player_y    sprite top-left corner (registered)
//   dir                   0 right, 1 left, 2 up, 3 down (registered)
//   moving                player advancing each frame (registered)
//   player_pixel          scan position inside the SIZE x SIZE sprite box
module player_motion #(
  parameter int unsigned SIZE    = 16,
  parameter int unsigned STEP    = 2,
  parameter int unsigned GRID    = 8,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 624,
  parameter int unsigned Y_MIN   = 0,
  parameter int unsigned Y_MAX   = 464,
  parameter int unsigned SPAWN_X = 312,
  parameter int unsigned SPAWN_Y = 232
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        soft_reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic [10:0] h_cnt,
  input  logic [9:0]  v_cnt,
  output logic [9:0]  player_x,
  output logic [9:0]  player_y,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        player_pixel
);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] SIZE11 = 11'(SIZE);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMIN11 = 11'(Y_MIN);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);
  localparam logic [9:0]  SPX    = 10'(SPAWN_X);
  localparam logic [9:0]  SPY    = 10'(SPAWN_Y);
  localparam logic [9:0]  GMASK  = 10'(GRID - 1);

  // bit order {up, down, left, right}
  logic [3:0]  sync1, sync2;
  dir_t        dir_q, dir_n, pend_dir, pend_dir_n;
  logic        moving_q, moving_n, pend_valid, pend_valid_n, turn_ok;
  logic [9:0]  x_q, y_q, x_n, y_n;
  logic [10:0] x_ext, y_ext, v_ext;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign v_ext = {1'b0, v_cnt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_up, btn_down, btn_left, btn_right};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= SPX;
      y_q        <= SPY;
      dir_q      <= DIR_LEFT;
      moving_q   <= 1'b0;
      pend_dir   <= DIR_RIGHT;
      pend_valid <= 1'b0;
    end else begin
      x_q        <= x_n;
      y_q        <= y_n;
      dir_q      <= dir_n;
      moving_q   <= moving_n;
      pend_dir   <= pend_dir_n;
      pend_valid <= pend_valid_n;
    end
  end

  always_comb begin
    x_n          = x_q;
    y_n          = y_q;
    dir_n        = dir_q;
    moving_n     = moving_q;
    pend_dir_n   = pend_dir;
    pend_valid_n = pend_valid;
    turn_ok      = 1'b0;

    if (sync2[3]) begin
      pend_dir_n   = DIR_UP;
      pend_valid_n = 1'b1;
    end else if (sync2[2]) begin
      pend_dir_n   = DIR_DOWN;
      pend_valid_n = 1'b1;
    end else if (sync2[1]) begin
      pend_dir_n   = DIR_LEFT;
      pend_valid_n = 1'b1;
    end else if (sync2[0]) begin
      pend_dir_n   = DIR_RIGHT;
      pend_valid_n = 1'b1;
    end

    if (soft_reset) begin
      x_n          = SPX;
      y_n          = SPY;
      dir_n        = DIR_LEFT;
      moving_n     = 1'b0;
      pend_valid_n = 1'b0;
    end else if (frame_tick) begin
      // opposite directions differ only in bit 0 of the encoding
      turn_ok = pend_valid &&
                (!moving_q || ((pend_dir ^ dir_q) == 2'b01) ||
                 (((x_q & GMASK) == '0) && ((y_q & GMASK) == '0)));
      if (turn_ok) begin
        dir_n        = pend_dir;
        pend_valid_n = 1'b0;  // consume overrides a same-clk capture
      end
      if (turn_ok || moving_q) begin
        moving_n = 1'b1;
        // clamp decisions are made at 11 bits before truncating
        unique case (dir_n)
          DIR_RIGHT:
            if (x_ext >= XMAX11)                moving_n = 1'b0;
            else if (x_ext + STEP11 >= XMAX11)  x_n = 10'(XMAX11);
            else                                x_n = 10'(x_ext + STEP11);
          DIR_LEFT:
            if (x_ext <= XMIN11)                moving_n = 1'b0;
            else if (x_ext < XMIN11 + STEP11)   x_n = 10'(XMIN11);
            else                                x_n = 10'(x_ext - STEP11);
          DIR_DOWN:
            if (y_ext >= YMAX11)                moving_n = 1'b0;
            else if (y_ext + STEP11 >= YMAX11)  y_n = 10'(YMAX11);
            else                                y_n = 10'(y_ext + STEP11);
          DIR_UP:
            if (y_ext <= YMIN11)                moving_n = 1'b0;
            else if (y_ext < YMIN11 + STEP11)   y_n = 10'(YMIN11);
            else                                y_n = 10'(y_ext - STEP11);
          default: moving_n = 1'b0;
        endcase
      end
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign dir          = dir_q;
  assign moving       = moving_q;
  assign player_pixel = (h_cnt >= x_ext) && (h_cnt < x_ext + SIZE11) &&
                        (v_ext >= y_ext) && (v_ext < y_ext + SIZE11);

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: reset, start, grid-gated turns,
// reversals, wall clamps, button priority and soft_reset behaviour.
module tb_player_motion;

  logic        clk = 1'b0;
  logic        rst, soft_reset, frame_tick;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  player_x, player_y;
  logic [1:0]  dir;
  logic        moving, player_pixel;

  int checks = 0;
  int errors = 0;

  player_motion dut (
    .clk          (clk),
    .rst          (rst),
    .soft_reset   (soft_reset),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .player_x     (player_x),
    .player_y     (player_y),
    .dir          (dir),
    .moving       (moving),
    .player_pixel (player_pixel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // b = {up, down, left, right}; hold 3 clks, then let synchronisers drain
  task automatic press(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (3) step();
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (2) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int d, input int m);
    chk({tag, "_x"}, 32'(player_x), 32'(x));
    chk({tag, "_y"}, 32'(player_y), 32'(y));
    chk({tag, "_dir"}, 32'(dir), 32'(d));
    chk({tag, "_moving"}, 32'(moving), 32'(m));
  endtask

  initial begin
    rst = 1'b0; soft_reset = 1'b0; frame_tick = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    h_cnt = '0; v_cnt = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // reset state, idle frames
    repeat (5) tick();
    chk_pos("reset", 312, 232, 1, 0);
    chk("reset_pend_valid", 32'(dut.pend_valid), 0);

    // sprite box edges
    h_cnt = 11'd312; v_cnt = 10'd232; #1;
    chk("pix_corner", 32'(player_pixel), 1);
    h_cnt = 11'd328; #1;
    chk("pix_right_out", 32'(player_pixel), 0);
    h_cnt = 11'd327; v_cnt = 10'd247; #1;
    chk("pix_far_corner", 32'(player_pixel), 1);
    v_cnt = 10'd248; #1;
    chk("pix_bottom_out", 32'(player_pixel), 0);
    h_cnt = 11'd311; v_cnt = 10'd240; #1;
    chk("pix_left_out", 32'(player_pixel), 0);

    // synchroniser latency: visible on 3rd clk after raw edge
    btn_right = 1'b1;
    step(); step();
    chk("sync_lat2", 32'(dut.pend_valid), 0);
    step();
    chk("sync_lat3", 32'(dut.pend_valid), 1);
    chk("sync_dir", 32'(dut.pend_dir), 0);
    step();
    btn_right = 1'b0;
    repeat (5) step();
    chk("pend_held", 32'(dut.pend_valid), 1);

    // start and run
    tick(); chk_pos("run1", 314, 232, 0, 1);
    chk("run1_consumed", 32'(dut.pend_valid), 0);

    // grid-gated turn up
    press(4'b1000);
    chk("up_pend_dir", 32'(dut.pend_dir), 2);
    tick(); chk_pos("gate316", 316, 232, 0, 1);
    tick(); chk_pos("gate318", 318, 232, 0, 1);
    tick(); chk_pos("gate320", 320, 232, 0, 1);
    tick(); chk_pos("turn_up", 320, 230, 2, 1);

    // right while moving up at y=230: not aligned, stays pending
    press(4'b0001);
    tick(); chk_pos("no_turn", 320, 228, 2, 1);
    chk("still_pend", 32'(dut.pend_valid), 1);
    // overwrite with down: reversal applies immediately
    press(4'b0100);
    tick(); chk_pos("rev_down", 320, 230, 3, 1);
    press(4'b0001);
    tick(); chk_pos("down232", 320, 232, 3, 1);
    tick(); chk_pos("turn_right", 322, 232, 0, 1);
    press(4'b0010);
    tick(); chk_pos("rev_left", 320, 232, 1, 1);

    // right wall
    press(4'b0001);
    tick(); chk_pos("rev_right", 322, 232, 0, 1);
    repeat (150) tick();
    chk_pos("near_right", 622, 232, 0, 1);
    tick(); chk_pos("right_clamp", 624, 232, 0, 1);
    tick(); chk_pos("right_stop", 624, 232, 0, 0);
    tick(); chk_pos("right_idle", 624, 232, 0, 0);

    // left wall
    press(4'b0010);
    tick(); chk_pos("restart_left", 622, 232, 1, 1);
    repeat (311) tick();
    chk_pos("left_clamp", 0, 232, 1, 1);
    tick(); chk_pos("left_stop", 0, 232, 1, 0);

    // priority: up beats right
    press(4'b1001);
    chk("prio_dir", 32'(dut.pend_dir), 2);
    chk("prio_valid", 32'(dut.pend_valid), 1);
    tick(); chk_pos("prio_move", 0, 230, 2, 1);

    // soft_reset beats frame_tick; held button re-captures next clk
    btn_down = 1'b1;
    repeat (3) step();
    chk("held_pend", 32'(dut.pend_dir), 3);
    soft_reset = 1'b1; frame_tick = 1'b1;
    step();
    soft_reset = 1'b0; frame_tick = 1'b0;
    chk_pos("soft_reset", 312, 232, 1, 0);
    chk("soft_pend_clr", 32'(dut.pend_valid), 0);
    step();
    chk("recapture", 32'(dut.pend_valid), 1);
    chk("recapture_dir", 32'(dut.pend_dir), 3);
    btn_down = 1'b0;
    repeat (3) step();
    chk_pos("stable", 312, 232, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
